// File: rtl/pcie_crdt_tracker.sv
// PCIe flow-control credit tracker. Collects the link partner's initial P/NP/CPL
// header and data credits, then grants requests and tracks consumption and updates.
module pcie_crdt_tracker #(
  parameter int HDR_UPD_W  = 2,
  parameter int DATA_UPD_W = 4,
  parameter int CNT_W      = 16,
  parameter int REQ_DATA_W = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  crdt_init_done,
  input  logic [5:0]            crdt_update,
  input  logic [HDR_UPD_W-1:0]  crdt_cnt_ph,
  input  logic [HDR_UPD_W-1:0]  crdt_cnt_nph,
  input  logic [HDR_UPD_W-1:0]  crdt_cnt_cplh,
  input  logic [DATA_UPD_W-1:0] crdt_cnt_pd,
  input  logic [DATA_UPD_W-1:0] crdt_cnt_npd,
  input  logic [DATA_UPD_W-1:0] crdt_cnt_cpld,
  input  logic                  req_vld,
  input  logic [1:0]            req_type,
  input  logic [REQ_DATA_W-1:0] req_data,
  output logic                  req_ack,
  output logic [6*CNT_W-1:0]    avail,
  output logic [5:0]            infinite,
  output logic                  ready,
  output logic                  err_ovf
);
  localparam int SUM_W = CNT_W + 1;
  localparam int CMP_W = (CNT_W > REQ_DATA_W) ? CNT_W : REQ_DATA_W;
  localparam logic [SUM_W-1:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

  typedef enum logic [1:0] {IDLE = 2'd0, INIT = 2'd1, RUN = 2'd2} state_t;

  state_t                state_reg;
  state_t                state_next;
  logic [5:0][CNT_W-1:0] cnt_cur;
  logic [5:0][SUM_W-1:0] upd_amt;
  logic [5:0]            inf_cur;
  logic [5:0]            ovf_hit;
  logic [3:0]            type_ok;
  logic                  accumulate;
  logic                  enter_run;
  logic                  err_ovf_reg;

  // Counter index follows the crdt_update bit order: PH=5 ... CPLD=0.
  assign upd_amt[5] = crdt_update[5] ? SUM_W'(crdt_cnt_ph)   : '0;
  assign upd_amt[4] = crdt_update[4] ? SUM_W'(crdt_cnt_nph)  : '0;
  assign upd_amt[3] = crdt_update[3] ? SUM_W'(crdt_cnt_cplh) : '0;
  assign upd_amt[2] = crdt_update[2] ? SUM_W'(crdt_cnt_pd)   : '0;
  assign upd_amt[1] = crdt_update[1] ? SUM_W'(crdt_cnt_npd)  : '0;
  assign upd_amt[0] = crdt_update[0] ? SUM_W'(crdt_cnt_cpld) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = INIT;
      INIT:    if (crdt_init_done) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready   = (state_reg == RUN);
    req_ack = (state_reg == RUN) && req_vld && type_ok[req_type];
  end

  assign accumulate = (state_reg == INIT) || (state_reg == RUN);
  assign enter_run  = (state_reg == INIT) && crdt_init_done;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_type
      localparam int HK = 5 - gi;
      localparam int DK = 2 - gi;
      assign type_ok[gi] = (inf_cur[HK] || (cnt_cur[HK] != '0)) &&
                           (inf_cur[DK] || (CMP_W'(cnt_cur[DK]) >= CMP_W'(req_data)));
    end

    for (gi = 0; gi < 6; gi++) begin : g_cnt
      localparam logic [1:0] TYPE = (gi >= 3) ? 2'(5 - gi) : 2'(2 - gi);
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             inf_reg;
      logic [SUM_W-1:0] cons_amt;
      logic [SUM_W-1:0] sum;
      logic             hit;
      logic             ovf;

      assign hit = req_ack && (req_type == TYPE);
      if (gi >= 3) begin : g_hdr
        assign cons_amt = hit ? SUM_W'(1) : '0;
      end else begin : g_data
        // A grant implies req_data <= counter, so narrowing cannot lose bits.
        assign cons_amt = hit ? SUM_W'(req_data) : '0;
      end

      always_comb begin
        sum      = SUM_W'(cnt_reg) + upd_amt[gi] - cons_amt;
        cnt_next = cnt_reg;
        ovf      = 1'b0;
        if (accumulate && !inf_reg) begin
          if (sum > CNT_MAX) begin
            cnt_next = CNT_MAX[CNT_W-1:0];
            ovf      = 1'b1;
          end else begin
            cnt_next = sum[CNT_W-1:0];
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg <= '0;
          inf_reg <= 1'b0;
        end else begin
          cnt_reg <= cnt_next;
          if (enter_run) inf_reg <= (cnt_next == '0);
        end
      end

      assign cnt_cur[gi] = cnt_reg;
      assign inf_cur[gi] = inf_reg;
      assign ovf_hit[gi] = ovf;
    end
  endgenerate

  assign type_ok[3] = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_ovf_reg <= 1'b0;
    end else if (|ovf_hit) begin
      err_ovf_reg <= 1'b1;
    end
  end

  assign avail    = cnt_cur;
  assign infinite = inf_cur;
  assign err_ovf  = err_ovf_reg;
endmodule

// File: tb/tb_pcie_crdt_tracker.sv
// Randomized and directed bench for pcie_crdt_tracker at CNT_W=16 and CNT_W=8, checked
// through a scoreboard fed by a credit-arithmetic reference model.
`timescale 1ns/1ps
module tb_pcie_crdt_tracker;
  localparam int HW = 2;
  localparam int DW = 4;
  localparam int RW = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          crdt_init_done = 1'b0;
  logic [5:0]    crdt_update = '0;
  logic [HW-1:0] cnt_ph = '0, cnt_nph = '0, cnt_cplh = '0;
  logic [DW-1:0] cnt_pd = '0, cnt_npd = '0, cnt_cpld = '0;
  logic          req_vld = 1'b0;
  logic [1:0]    req_type = '0;
  logic [RW-1:0] req_data = '0;

  logic        ack16, ack8, rdy16, rdy8, ovf16, ovf8;
  logic [95:0] av16;
  logic [47:0] av8;
  logic [5:0]  inf16, inf8;

  always #5 clk = ~clk;

  pcie_crdt_tracker u_dut16 (
    .clk(clk), .rst(rst), .crdt_init_done(crdt_init_done), .crdt_update(crdt_update),
    .crdt_cnt_ph(cnt_ph), .crdt_cnt_nph(cnt_nph), .crdt_cnt_cplh(cnt_cplh),
    .crdt_cnt_pd(cnt_pd), .crdt_cnt_npd(cnt_npd), .crdt_cnt_cpld(cnt_cpld),
    .req_vld(req_vld), .req_type(req_type), .req_data(req_data),
    .req_ack(ack16), .avail(av16), .infinite(inf16), .ready(rdy16), .err_ovf(ovf16)
  );

  pcie_crdt_tracker #(.CNT_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .crdt_init_done(crdt_init_done), .crdt_update(crdt_update),
    .crdt_cnt_ph(cnt_ph), .crdt_cnt_nph(cnt_nph), .crdt_cnt_cplh(cnt_cplh),
    .crdt_cnt_pd(cnt_pd), .crdt_cnt_npd(cnt_npd), .crdt_cnt_cpld(cnt_cpld),
    .req_vld(req_vld), .req_type(req_type), .req_data(req_data),
    .req_ack(ack8), .avail(av8), .infinite(inf8), .ready(rdy8), .err_ovf(ovf8)
  );

  typedef struct packed {
    logic [1:0]  ack;
    logic [95:0] av16;
    logic [47:0] av8;
    logic [5:0]  inf16;
    logic [5:0]  inf8;
    logic        ready;
    logic [1:0]  ovf;
    logic        vld;
    logic [1:0]  typ;
    logic [10:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Stimulus for the next cycle; credit amounts in PH,NPH,CPLH,PD,NPD,CPLD order.
  bit       s_rst, s_done, s_vld;
  bit [5:0] s_upd;
  int       s_amt[6];
  int       s_typ, s_data;

  // Reference model: one credit ledger per DUT instance (0: 16-bit, 1: 8-bit).
  longint m_cnt[2][6];
  bit     m_inf[2][6];
  bit     m_ovf[2];
  longint m_max[2] = '{65535, 255};
  int     m_phase = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] a16(input int k);
    return av16[(6-k)*16-1 -: 16];
  endfunction

  function automatic logic [7:0] a8(input int k);
    return av8[(6-k)*8-1 -: 8];
  endfunction

  task automatic clr();
    s_rst = 0; s_done = 0; s_vld = 0; s_upd = '0; s_typ = 0; s_data = 0;
    for (int k = 0; k < 6; k++) s_amt[k] = 0;
  endtask

  task automatic model_cycle(output exp_t e);
    e = '0;
    e.vld = s_vld; e.typ = s_typ[1:0]; e.data = s_data[10:0];
    if (s_rst) begin
      m_phase = 0;
      for (int w = 0; w < 2; w++) begin
        m_ovf[w] = 0;
        for (int k = 0; k < 6; k++) begin m_cnt[w][k] = 0; m_inf[w][k] = 0; end
      end
    end else begin
      for (int w = 0; w < 2; w++) begin
        bit a;
        a = 0;
        if (m_phase == 2 && s_vld && s_typ != 3)
          a = (m_inf[w][s_typ] || m_cnt[w][s_typ] >= 1) &&
              (m_inf[w][s_typ+3] || m_cnt[w][s_typ+3] >= s_data);
        e.ack[w] = a;
        if (m_phase != 0) begin
          for (int k = 0; k < 6; k++) begin
            longint n;
            if (!m_inf[w][k]) begin
              n = m_cnt[w][k] + (s_upd[5-k] ? s_amt[k] : 0);
              if (a && k == s_typ) n = n - 1;
              if (a && k == s_typ + 3) n = n - s_data;
              if (n > m_max[w]) begin n = m_max[w]; m_ovf[w] = 1; end
              m_cnt[w][k] = n;
            end
          end
        end
        if (m_phase == 1 && s_done)
          for (int k = 0; k < 6; k++) m_inf[w][k] = (m_cnt[w][k] == 0);
      end
      if (m_phase == 0) m_phase = 1;
      else if (m_phase == 1 && s_done) m_phase = 2;
    end
    e.ready = (m_phase == 2);
    for (int k = 0; k < 6; k++) begin
      e.av16[(6-k)*16-1 -: 16] = m_cnt[0][k][15:0];
      e.av8[(6-k)*8-1 -: 8]    = m_cnt[1][k][7:0];
      e.inf16[5-k] = m_inf[0][k];
      e.inf8[5-k]  = m_inf[1][k];
    end
    e.ovf = {m_ovf[1], m_ovf[0]};
  endtask

  task automatic cyc();
    exp_t e;
    @(negedge clk);
    rst = s_rst; crdt_init_done = s_done; crdt_update = s_upd;
    cnt_ph = s_amt[0][HW-1:0]; cnt_nph = s_amt[1][HW-1:0]; cnt_cplh = s_amt[2][HW-1:0];
    cnt_pd = s_amt[3][DW-1:0]; cnt_npd = s_amt[4][DW-1:0]; cnt_cpld = s_amt[5][DW-1:0];
    req_vld = s_vld; req_type = s_typ[1:0]; req_data = s_data[RW-1:0];
    model_cycle(e);
    sb_q.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: ack is sampled mid-cycle, registered outputs just after the edge.
  initial begin
    logic s16, s8;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      s16 = ack16; s8 = ack8;
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("sb_ack16", s16, e.ack[0]);   chk("sb_ack8", s8, e.ack[1]);
        chk("sb_avail16", av16, e.av16);  chk("sb_avail8", av8, e.av8);
        chk("sb_inf16", inf16, e.inf16);  chk("sb_inf8", inf8, e.inf8);
        chk("sb_ready16", rdy16, e.ready); chk("sb_ready8", rdy8, e.ready);
        chk("sb_ovf16", ovf16, e.ovf[0]); chk("sb_ovf8", ovf8, e.ovf[1]);
        if (e.vld)
          $display("txn type=%0d data=%0d ack16=%0d ack8=%0d", e.typ, e.data, s16, s8);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: run did not complete");
    $fatal(1);
  end

  initial begin
    bit [5:0] zero_mask;
    clr(); s_rst = 1; cyc(); cyc(); settle();
    chk("rst_ready", rdy16, 0); chk("rst_avail", av16, 0);
    chk("rst_inf", inf16, 0);   chk("rst_ovf", ovf16, 0);

    // Initial credits: PH 2+2, PD 8+8, everything else left at zero -> infinite
    clr(); cyc();
    s_upd = 6'b100100; s_amt[0] = 2; s_amt[3] = 8; cyc();
    s_done = 1; cyc(); settle();
    chk("init_ready", rdy16, 1); chk("init_ph", a16(0), 4);
    chk("init_pd", a16(3), 16);  chk("init_inf", inf16, 6'b011011);

    // Drain to PH=1/PD=8, then exact-fit grant followed by refusal
    clr(); s_vld = 1; s_typ = 0; s_data = 8; cyc();
    s_data = 0; cyc(); cyc();
    s_data = 8; cyc(); #1 chk("p_exact_ack", ack16, 1);
    settle(); chk("p_exact_ph", a16(0), 0); chk("p_exact_pd", a16(3), 0);
    cyc(); #1 chk("p_empty_nak", ack16, 0);

    // Ack decision uses the pre-update count
    clr(); s_upd = 6'b100100; s_amt[0] = 3; s_amt[3] = 3; cyc();
    clr(); s_vld = 1; s_data = 4; s_upd = 6'b000100; s_amt[3] = 4; cyc();
    #1 chk("pd_short_nak", ack16, 0);
    settle(); chk("pd_after_upd", a16(3), 7);
    clr(); s_vld = 1; s_data = 4; cyc(); #1 chk("pd_retry_ack", ack16, 1);
    settle(); chk("pd_retry_pd", a16(3), 3); chk("pd_retry_ph", a16(0), 2);

    // Infinite CPL credits: every request granted, updates ignored
    clr(); s_vld = 1; s_typ = 2; s_data = 64; s_upd = 6'b001001; s_amt[2] = 3; s_amt[5] = 15;
    for (int i = 0; i < 100; i++) begin
      cyc(); #1 chk("cpl_inf_ack", ack16, 1);
    end
    settle();
    chk("cpl_cplh", a16(2), 0); chk("cpl_cpld", a16(5), 0);
    chk("cpl_ph", a16(0), 2);   chk("cpl_pd", a16(3), 3);

    // Reset in RUN discards credits immediately
    clr(); s_upd = 6'b100000; s_amt[0] = 1; cyc(); settle();
    chk("pre_rst_ph", a16(0), 3);
    clr(); s_rst = 1; s_vld = 1; cyc(); #1
    chk("rst_mid_ack", ack16, 0); chk("rst_mid_ready", rdy16, 0); chk("rst_mid_ph", a16(0), 0);
    cyc();

    // Fresh INIT up to PD=250, then overflow on the 8-bit instance
    clr(); cyc();
    s_upd = 6'b100100; s_amt[0] = 3; s_amt[3] = 10; cyc();
    s_upd = 6'b000100; s_amt[3] = 15; repeat (16) cyc();
    clr(); s_done = 1; cyc(); settle();
    chk("reinit_ready", rdy16, 1); chk("reinit_ph", a16(0), 3);
    chk("reinit_pd8", a8(3), 250); chk("reinit_inf", inf16, 6'b011011);
    clr(); s_upd = 6'b000100; s_amt[3] = 15; cyc(); settle();
    chk("sat_pd8", a8(3), 255);   chk("sat_ovf8", ovf8, 1);
    chk("sat_pd16", a16(3), 265); chk("sat_ovf16", ovf16, 0);
    clr(); repeat (3) cyc(); settle();
    chk("sat_ovf8_sticky", ovf8, 1);

    // Random traffic with occasional resets and per-epoch zero-credit types
    clr(); s_rst = 1; cyc();
    zero_mask = 6'($urandom);
    for (int i = 0; i < 900; i++) begin
      s_rst = ($urandom_range(0, 299) == 0);
      if (s_rst) zero_mask = 6'($urandom);
      s_done = ($urandom_range(0, 9) == 0);
      s_upd = 6'($urandom) & ((m_phase == 2) ? 6'h3f : ~zero_mask);
      for (int k = 0; k < 6; k++)
        s_amt[k] = (k < 3) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
      s_vld = $urandom_range(0, 1);
      s_typ = $urandom_range(0, 3);
      s_data = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 2047))
                                             : int'($urandom_range(0, 24));
      cyc();
    end

    clr(); cyc();
    repeat (3) @(posedge clk);
    #2;
    chk("sb_drain", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pcie_crdt_tracker.md
PCIE_CRDT_TRACKER -- requirements
Module: pcie_crdt_tracker

Interface
REQ-001 SHALL have parameter HDR_UPD_W, default 2, width of each header-credit update count.
REQ-002 SHALL have parameter DATA_UPD_W, default 4, width of each data-credit update count.
REQ-003 SHALL have parameter CNT_W, default 16, width of each internal credit counter; legal range 8..32.
REQ-004 SHALL have parameter REQ_DATA_W, default 11, width of per-request data-credit demand.
REQ-005 SHALL have ports: CLK in 1 clock; RST in 1 reset; both listed first.
REQ-006 SHALL have CRDT_INIT_DONE in 1, link partner finished advertising initial credits.
REQ-007 SHALL have CRDT_UPDATE in 6, valid flags {PH,NPH,CPLH,PD,NPD,CPLD} with PH at MSB.
REQ-008 SHALL have CRDT_CNT_PH/NPH/CPLH in HDR_UPD_W each, and CRDT_CNT_PD/NPD/CPLD in DATA_UPD_W each, increments qualified by the matching CRDT_UPDATE bit.
REQ-009 SHALL have REQ_VLD in 1, REQ_TYPE in 2 (0=P, 1=NP, 2=CPL, 3=reserved), and REQ_DATA in REQ_DATA_W (data credits needed, 1 credit = 4 DW).
REQ-010 SHALL have REQ_ACK out 1, request granted and credits consumed this cycle.
REQ-011 SHALL have AVAIL out 6*CNT_W, current counters in REQ-007 order, and INFINITE out 6, per-type infinite flags.
REQ-012 SHALL have READY out 1 (state RUN) and ERR_OVF out 1, sticky counter-overflow flag.
REQ-013 SHALL use one clock, CLK; reset RST asynchronous, active-high.

Function
REQ-014 SHALL implement FSM IDLE -> INIT -> RUN; IDLE leaves to INIT on the first cycle after reset release.
REQ-015 SHALL, in INIT, add each flagged update count to its counter and never assert REQ_ACK.
REQ-016 SHALL move INIT -> RUN on the first cycle CRDT_INIT_DONE=1; updates in that same cycle are still accumulated.
REQ-017 SHALL, on entering RUN, set INFINITE[i]=1 for every counter equal to 0 (update bit included); INFINITE is then frozen until reset.
REQ-018 SHALL keep an INFINITE counter's value unchanged: no updates, no consumption.
REQ-019 SHALL assert REQ_ACK combinationally, in RUN only, when REQ_VLD=1, REQ_TYPE!=3, header credit of the type is >=1 or infinite, and data credit of the type is >=REQ_DATA or infinite.
REQ-020 SHALL, on REQ_ACK, subtract 1 header and REQ_DATA data credits of the type at the next CLK edge; REQ_DATA=0 consumes no data credit.
REQ-021 SHALL compute next = cnt + update - consumed when an update and a consumption of the same type occur in one cycle; the ACK check uses pre-update cnt.
REQ-022 SHALL saturate any counter at 2^CNT_W-1 and set ERR_OVF when an addition would exceed it.
REQ-023 SHALL never ACK REQ_TYPE=3 and never hold state for an unacknowledged request (requester retries).
REQ-024 SHALL drive AVAIL and INFINITE from registers (1-cycle latency after update or consumption).
REQ-025 SHALL ignore CRDT_INIT_DONE deassertion in RUN; only reset returns to IDLE.

Reset
REQ-026 SHALL, on RST=1, immediately clear all counters, INFINITE, ERR_OVF, REQ_ACK, READY and force state IDLE.
REQ-027 SHALL, on reset mid-RUN, discard all credits; the new INIT phase starts from zero.

Verification
REQ-028 Init PH=4 by two updates of 2, PD=16, INIT_DONE -> READY=1 next cycle, AVAIL.PH=4, AVAIL.PD=16, INFINITE=6'b011011.
REQ-029 RUN, PH=1, PD=8, request P REQ_DATA=8 -> REQ_ACK=1; next cycle PH=0, PD=0; repeat request -> REQ_ACK=0.
REQ-030 RUN, PD=3, request P REQ_DATA=4 with simultaneous PD update +4 -> REQ_ACK=0, next PD=7; retry -> ACK, PD=3.
REQ-031 CPLH and CPLD infinite, 100 back-to-back CPL requests REQ_DATA=64 -> all ACK, counters unchanged, AVAIL.CPLD=0.
REQ-032 CNT_W=8, PD=250, update +15 -> PD=255, ERR_OVF=1 and stays 1.
REQ-033 RST pulse mid-RUN with PH=3 -> PH=0, READY=0, REQ_ACK=0 during reset; INIT repeats cleanly.
